multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 159 +++++++++++++++
 tb/tb_multi_debouncer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   NB_CH independent button debouncers sharing one clock. Each channel runs
//   its raw level through a SYNC_STAGES-deep synchronizer, then accepts a new
//   level only after DEB_TIME consecutive cycles in which the synchronized
//   value disagrees with the current debounced level. One-cycle rise/fall
//   pulses accompany every accepted change.
//
//   Optional feature (macro MULTI_DEBOUNCER_LONG_PRESS_EN):
//     per-channel long-press detection. long_press asserts once the debounced
//     level has been high for LONG_TIME cycles and drops together with fall.
//     Without the macro, long_press is tied to 0 and LONG_TIME is unused.
//
// Ports
//   aclk             in   single clock
//   arstn            in   asynchronous active-low reset
//   button           in   [NB_CH] raw asynchronous button levels
//   button_debounced out  [NB_CH] registered debounced levels
//   rise             out  [NB_CH] one-cycle pulse on debounced 0->1
//   fall             out  [NB_CH] one-cycle pulse on debounced 1->0
//   long_press       out  [NB_CH] level flag for a held button
// -----------------------------------------------------------------------------
module multi_debouncer #(
  parameter int NB_CH       = 4,
  parameter int DEB_TIME    = 100,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_TIME   = 1000
) (
  input  logic             aclk,
  input  logic             arstn,
  input  logic [NB_CH-1:0] button,
  output logic [NB_CH-1:0] button_debounced,
  output logic [NB_CH-1:0] rise,
  output logic [NB_CH-1:0] fall,
  output logic [NB_CH-1:0] long_press
);

  localparam int CW = $clog2(DEB_TIME + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TIME - 1);

  // Elaboration-time range checks on the configuration.
  if (NB_CH < 1 || NB_CH > 32) begin : g_bad_nb_ch
    $error("multi_debouncer: NB_CH must be 1..32");
  end
  if (DEB_TIME < 1 || DEB_TIME > 65535) begin : g_bad_deb_time
    $error("multi_debouncer: DEB_TIME must be 1..65535");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("multi_debouncer: SYNC_STAGES must be 2..4");
  end
  if (LONG_TIME < 1) begin : g_bad_long_time
    $error("multi_debouncer: LONG_TIME must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizer: stage 0 samples the raw pins, last stage is "sync".
  // ---------------------------------------------------------------------------
  logic [NB_CH-1:0] sync_q [SYNC_STAGES];
  logic [NB_CH-1:0] sync;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= button;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce counters: one per channel. A single agreeing cycle clears the
  // count, so only an unbroken run of DEB_TIME disagreeing cycles toggles.
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    cnt_q [NB_CH];
  logic [CW-1:0]    cnt_d [NB_CH];
  logic [NB_CH-1:0] deb_q, deb_d;
  logic [NB_CH-1:0] rise_q, rise_d;
  logic [NB_CH-1:0] fall_q, fall_d;

  always_comb begin
    deb_d = deb_q;
    for (int ch = 0; ch < NB_CH; ch++) begin
      cnt_d[ch] = '0;
      if (sync[ch] != deb_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          deb_d[ch] = ~deb_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
    // Registered alongside the level, so the pulse lines up with the first
    // cycle of the new debounced value.
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int ch = 0; ch < NB_CH; ch++) cnt_q[ch] <= '0;
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int ch = 0; ch < NB_CH; ch++) cnt_q[ch] <= cnt_d[ch];
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign button_debounced = deb_q;
  assign rise             = rise_q;
  assign fall             = fall_q;

  // ---------------------------------------------------------------------------
  // Long-press detection
  // ---------------------------------------------------------------------------
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_TIME + 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TIME);

  logic [LW-1:0]    lp_cnt_q [NB_CH];
  logic [LW-1:0]    lp_cnt_d [NB_CH];
  logic [NB_CH-1:0] lp_q, lp_d;

  // The count advances only across edges where the level is high both
  // before and after, so it is 0 on the rise cycle and LONG_TIME exactly
  // LONG_TIME cycles later. Because it is computed from deb_d, the flag
  // drops on the same edge that produces fall.
  always_comb begin
    for (int ch = 0; ch < NB_CH; ch++) begin
      lp_cnt_d[ch] = '0;
      if (deb_q[ch] && deb_d[ch]) begin
        lp_cnt_d[ch] = (lp_cnt_q[ch] == LONG_MAX) ? LONG_MAX
                                                  : lp_cnt_q[ch] + LW'(1);
      end
      lp_d[ch] = (lp_cnt_d[ch] == LONG_MAX);
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int ch = 0; ch < NB_CH; ch++) lp_cnt_q[ch] <= '0;
      lp_q <= '0;
    end else begin
      for (int ch = 0; ch < NB_CH; ch++) lp_cnt_q[ch] <= lp_cnt_d[ch];
      lp_q <= lp_d;
    end
  end

  assign long_press = lp_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//   Bench for multi_debouncer (NB_CH=4, DEB_TIME=8, SYNC_STAGES=2,
//   LONG_TIME=20). A reference model derived from the window rule ("the last
//   DEB_TIME synchronized samples all disagree with the debounced level")
//   pushes one expected output vector per clock into exp_q; a monitor pops
//   and compares on the falling edge. Directed sequences add latency checks.
//   Define MULTI_DEBOUNCER_LONG_PRESS_EN to build with long-press enabled.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

  localparam int NB_CH       = 4;
  localparam int DEB_TIME    = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LONG_TIME   = 20;
  localparam int W           = 4 * NB_CH;
  localparam int LATENCY     = SYNC_STAGES + DEB_TIME;

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  localparam int SEL_DEB  = 0;
  localparam int SEL_RISE = 1;
  localparam int SEL_FALL = 2;
  localparam int SEL_LONG = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             aclk   = 1'b0;
  logic             arstn  = 1'b0;
  logic [NB_CH-1:0] button = '0;
  logic [NB_CH-1:0] button_debounced;
  logic [NB_CH-1:0] rise;
  logic [NB_CH-1:0] fall;
  logic [NB_CH-1:0] long_press;
  logic [W-1:0]     dut_vec;

  always #5 aclk = ~aclk;

  multi_debouncer #(
    .NB_CH      (NB_CH),
    .DEB_TIME   (DEB_TIME),
    .SYNC_STAGES(SYNC_STAGES),
    .LONG_TIME  (LONG_TIME)
  ) dut (
    .aclk            (aclk),
    .arstn           (arstn),
    .button          (button),
    .button_debounced(button_debounced),
    .rise            (rise),
    .fall            (fall),
    .long_press      (long_press)
  );

  assign dut_vec = {long_press, fall, rise, button_debounced};

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_vec(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: keeps the raw button history and the synchronized-sample
  // window, and decides each channel's level from the window contents.
  // ---------------------------------------------------------------------------
  logic [NB_CH-1:0] btn_hist[$];
  logic [NB_CH-1:0] sync_hist[$];
  logic [NB_CH-1:0] m_deb;
  int               held [NB_CH];
  logic [NB_CH-1:0] m_s, m_nd, m_lp;
  bit               all_diff;

  always @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      btn_hist.delete();
      sync_hist.delete();
      m_deb = '0;
      for (int ch = 0; ch < NB_CH; ch++) held[ch] = 0;
    end else begin
      // Value the debounce logic sees at this edge: button from SYNC_STAGES
      // edges ago, or 0 if reset was that recent.
      m_s = (btn_hist.size() >= SYNC_STAGES) ?
            btn_hist[btn_hist.size() - SYNC_STAGES] : '0;
      btn_hist.push_back(button);
      if (btn_hist.size() > 8) void'(btn_hist.pop_front());
      sync_hist.push_back(m_s);
      if (sync_hist.size() > DEB_TIME) void'(sync_hist.pop_front());

      m_nd = m_deb;
      for (int ch = 0; ch < NB_CH; ch++) begin
        if (sync_hist.size() == DEB_TIME) begin
          all_diff = 1'b1;
          foreach (sync_hist[k]) if (sync_hist[k][ch] == m_deb[ch]) all_diff = 1'b0;
          if (all_diff) m_nd[ch] = ~m_deb[ch];
        end
      end

      for (int ch = 0; ch < NB_CH; ch++) begin
        if (m_nd[ch] && m_deb[ch]) held[ch]++;
        else held[ch] = 0;
        m_lp[ch] = LP_EN && (held[ch] >= LONG_TIME);
      end

      exp_q.push_back({m_lp, m_deb & ~m_nd, m_nd & ~m_deb, m_nd});
      m_deb = m_nd;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge aclk) begin
    if (!arstn) begin
      exp_q.delete();
      check_vec("reset_outputs", dut_vec, '0);
    end else if (exp_q.size() > 0) begin
      check_vec("scoreboard", dut_vec, exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [NB_CH-1:0] val);
    @(posedge aclk);
    #1 button = val;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
  endtask

  // Counts clock edges until the selected output bit of channel ch is seen
  // high (sampled on the falling edge); -1 if the bound expires.
  task automatic measure(input int ch, input int sel, input int bound,
                         output int cyc);
    logic [NB_CH-1:0] v;
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      case (sel)
        SEL_DEB:  v = button_debounced;
        SEL_RISE: v = rise;
        SEL_FALL: v = fall;
        default:  v = long_press;
      endcase
      if (v[ch]) begin
        cyc = i;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int c;
  int used;

  initial begin
    button = '0;
    arstn  = 1'b0;
    wait_cycles(3);
    #1 arstn = 1'b1;

    // Idle after reset release.
    wait_cycles(50);
    @(negedge aclk);
    check_vec("idle_after_reset", dut_vec, '0);

    // Single channel press: latency and one-cycle rise.
    drive(4'b0001);
    measure(0, SEL_DEB, 20, c);
    check_int("ch0_latency", c, LATENCY);
    check_int("ch0_rise", int'(rise), 1);
    check_int("ch0_other_channels", int'(button_debounced), 1);
    @(negedge aclk);
    check_int("ch0_rise_width", int'(rise), 0);

    // Channel 1 toggling every 5 cycles never gets through.
    for (int i = 0; i < 20; i++) begin
      drive(button ^ 4'b0010);
      wait_cycles(4);
    end
    @(negedge aclk);
    check_int("ch1_glitch_level", int'(button_debounced[1]), 0);

    // All channels together.
    drive(4'h0);
    wait_cycles(20);
    drive(4'hF);
    measure(1, SEL_RISE, 20, c);
    check_int("all_rise_latency", c, LATENCY);
    check_int("all_rise_same_cycle", int'(rise), 15);
    wait_cycles(19);
    drive(4'h0);
    measure(1, SEL_FALL, 20, c);
    check_int("all_fall_latency", c, LATENCY);
    check_int("all_fall_same_cycle", int'(fall), 15);

    // Reset mid-count (counter at 5), then a full debounce after release.
    wait_cycles(5);
    drive(4'b1000);
    wait_cycles(SYNC_STAGES + 5);
    #1 arstn = 1'b0;
    #1 check_vec("async_reset_clear", dut_vec, '0);
    wait_cycles(3);
    #1 arstn = 1'b1;
    measure(3, SEL_DEB, 20, c);
    check_int("post_reset_latency", c, LATENCY);
    check_int("post_reset_rise", int'(rise), 8);

    // Long press on channel 2.
    drive(4'h0);
    wait_cycles(20);
    drive(4'b0100);
    measure(2, SEL_RISE, 20, c);
    check_int("ch2_rise_latency", c, LATENCY);
    measure(2, SEL_LONG, 30, c);
    check_int("ch2_long_after_rise", c, LP_EN ? LONG_TIME : -1);
    used = (c > 0) ? c : 30;
    wait_cycles(40 - LATENCY - used);
    drive(4'h0);
    measure(2, SEL_FALL, 20, c);
    check_int("ch2_fall_latency", c, LATENCY);
    check_int("ch2_long_clears_with_fall", int'(long_press), 0);

    // Randomized traffic: short runs first, then longer holds, with an
    // occasional reset pulse.
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 400; n++) begin
        @(posedge aclk);
        #1;
        for (int ch = 0; ch < NB_CH; ch++) begin
          if ($urandom_range(0, (phase == 0) ? 5 : 24) == 0) button[ch] = ~button[ch];
        end
        arstn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      end
    end
    @(posedge aclk);
    #1 arstn = 1'b1;
    wait_cycles(3);
    @(negedge aclk);
    @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
